fetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
//  It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready port.

---
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem
// requests under a credit limit, buffers responses with their PC in a
// DEPTH-entry queue and hands them to IF/ID over valid/ready. A redirect
// flushes the queue and marks every in-flight response as stale.
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [63:0]                imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [31:0]                imem_resp_instr,
  input  logic                       redirect,
  input  logic [63:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [63:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       resp_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [63:0]     fetch_pc;
  logic [63:0]     resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     instr_q [DEPTH];
  logic [63:0]     pc_q    [DEPTH];
  logic [CW:0]     credit_sum;
  logic            resp_ok;
  logic            resp_live;
  logic            resp_drop;
  logic            req_fire;
  logic            pop;

  // Response classification: ignored (nothing outstanding), dropped (stale) or live.
  assign resp_ok    = imem_resp_valid && (outstanding != '0);
  assign resp_live  = resp_ok && (drop_cnt == '0);
  assign resp_drop  = resp_ok && (drop_cnt != '0);

  // Queue slots are reserved at request time, so a live response always fits.
  assign credit_sum     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state == RUN) && !redirect
                          && (outstanding < CW'(MAX_OUTSTANDING))
                          && (credit_sum < (CW + 1)'(DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = fetch_pc;

  assign out_valid = (count != '0) && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_instr = (count != '0) ? instr_q[rd_ptr] : '0;
  assign out_pc    = (count != '0) ? pc_q[rd_ptr]    : '0;
  assign occupancy = count;

  // Every request still in flight after a redirect is stale; drop_cnt is set to
  // that remaining count, which equals the old drop_cnt plus the newly stale ones.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect) begin
      drop_nxt = outstanding - CW'(resp_ok);
    end else if (resp_drop) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  // Outstanding request count: +1 on request handshake, -1 on any accepted response.
  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !resp_ok) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!req_fire && resp_ok) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // Next-state logic: HOLD for one cycle, DRAIN while stale responses remain.
  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    state_nxt = RUN;
      RUN:     if (redirect && (drop_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = HOLD;
    endcase
  end

  // Control state, PCs, counters and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HOLD;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      resp_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      if (imem_resp_valid && (outstanding == '0)) begin
        resp_err <= 1'b1;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (resp_live) begin
          resp_pc <= resp_pc + 64'd4;
        end
      end
    end
  end

  // Queue pointers and occupancy; redirect clears the queue ahead of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (resp_live) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (resp_live && !pop) begin
        count <= count + CW'(1);
      end else if (!resp_live && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage: live responses are written with the PC they were fetched from.
  always_ff @(posedge clk) begin
    if (resp_live && !redirect) begin
      instr_q[wr_ptr] <= imem_resp_instr;
      pc_q[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue. The reference keeps the
// queue as a list of PCs and each in-flight request as an (address, stale)
// pair; stale requests are exactly those issued before the latest redirect.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  occupancy;
  logic        resp_err;

  fetch_queue #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_instr(imem_resp_instr),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .occupancy(occupancy),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_q[$];      // PCs held in the queue, head first
  logic [63:0] m_mem[$];    // addresses the memory still owes a response for
  bit          m_stale[$];  // per in-flight request: issued before a redirect
  logic [63:0] m_fetch;
  bit          m_err;
  logic [63:0] popped[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 0);
    check({tag, "_req_addr"}, imem_req_addr, RPC);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pc"}, out_pc, 0);
    check({tag, "_out_instr"}, out_instr, 0);
    check({tag, "_occupancy"}, occupancy, 0);
    check({tag, "_resp_err"}, resp_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check_cleared("rst");
    end
    m_q.delete(); m_mem.delete(); m_stale.delete();
    m_fetch = RPC;
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("hold_req_valid", imem_req_valid, 0);
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic cycle(input bit rdy, input bit rsp, input bit ordy, input bit rd,
                       input logic [63:0] rpc, input bit unsol);
    bit          run, exp_req, exp_ov, rv, st;
    logic [63:0] a;
    st = 1'b1;
    a  = '0;
    @(negedge clk);
    rv = unsol || (rsp && (m_mem.size() != 0));
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_instr = (m_mem.size() != 0) ? ins_of(m_mem[0]) : 32'hDEAD_BEEF;
    out_ready       = ordy;
    redirect        = rd;
    redirect_pc     = rpc;
    #1;
    run = 1'b1;
    foreach (m_stale[i]) if (m_stale[i]) run = 1'b0;
    exp_req = run && !rd && (m_stale.size() < MAXO) && ((m_q.size() + m_stale.size()) < DEPTH);
    exp_ov  = (m_q.size() != 0) && !rd;
    check("req_valid", imem_req_valid, exp_req);
    check("req_addr", imem_req_addr, m_fetch);
    check("out_valid", out_valid, exp_ov);
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0]);
      check("out_instr", out_instr, ins_of(m_q[0]));
    end else begin
      check("out_pc_empty", out_pc, 0);
      check("out_instr_empty", out_instr, 0);
    end
    check("occupancy", occupancy, m_q.size());
    check("resp_err", resp_err, m_err);
    if (rv) begin
      if (m_stale.size() != 0) begin
        st = m_stale.pop_front();
        a  = m_mem.pop_front();
      end else begin
        m_err = 1'b1;
      end
    end
    if (exp_ov && ordy) popped.push_back(m_q.pop_front());
    if (rv && !st && !rd) m_q.push_back(a);
    if (rd) begin
      foreach (m_stale[i]) m_stale[i] = 1'b1;
      m_q.delete();
      m_fetch = rpc;
    end
    if (exp_req && rdy) begin
      m_stale.push_back(1'b0);
      m_mem.push_back(m_fetch);
      m_fetch = m_fetch + 64'd4;
    end
  endtask

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(9) == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
    return {$urandom, $urandom} & ~64'h3;
  endfunction

  initial begin
    bit seen;

    do_reset();

    // Streaming with a one-cycle memory and no stalls.
    popped.delete();
    repeat (12) cycle(1, 1, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      if (popped.size() > i) check("stream_pc", popped[i], 64'(i) * 4);
      else check("stream_count", popped.size(), i + 1);
    end

    // Backpressure until full, then release and confirm ordering.
    repeat (12) cycle(1, 1, 0, 0, '0, 0);
    @(posedge clk);
    #1;
    check("bp_full", occupancy, DEPTH);
    check("bp_noreq", imem_req_valid, 0);
    popped.delete();
    repeat (12) cycle(1, 1, 1, 0, '0, 0);
    for (int i = 1; i < popped.size(); i++) check("bp_order", popped[i], popped[i-1] + 64'd4);

    // Redirect to 0x100 with two requests in flight.
    repeat (3) cycle(1, 0, 1, 0, '0, 0);
    check("rd_inflight", m_stale.size(), 2);
    cycle(1, 0, 1, 1, 64'h100, 0);
    cycle(1, 1, 0, 0, '0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 1, 0, 0, '0, 0);
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        check("rd_first_pc", out_pc, 64'h100);
      end
    end
    if (!seen) check("rd_timeout", 0, 1);

    // Redirect coinciding with a response and a pop.
    repeat (4) cycle(1, 1, 1, 0, '0, 0);
    cycle(1, 0, 0, 0, '0, 0);
    cycle(1, 1, 1, 1, 64'h200, 0);
    @(posedge clk);
    #1 check("rd_same_cycle_empty", occupancy, 0);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 60,
            $urandom_range(99) < 5, rand_pc(), 0);
    end

    // Asynchronous reset while full, refetch, then an unsolicited response.
    repeat (12) cycle(1, 1, 0, 0, '0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_cleared("async");
    do_reset();
    cycle(1, 1, 1, 0, '0, 0);
    check("refetch_first", m_mem.size() > 0 ? m_mem[0] : 64'hBAD, RPC);
    repeat (6) cycle(1, 1, 1, 0, '0, 0);
    repeat (4) cycle(0, 1, 1, 0, '0, 0);
    check("drained", m_mem.size(), 0);
    cycle(0, 0, 1, 0, '0, 1);
    cycle(0, 0, 1, 0, '0, 0);
    check("unsol_err", resp_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
